// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the min_sort_engine slice.
package sort_pkg;

    localparam int SORT_M_DEF = 8;
    localparam int SORT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } sort_state_t;

endpackage

// File: rtl/min_slice.sv
// One bit-column step of the minimum search: narrow the candidate set to
// words whose column bit is 0, unless that would empty the set.
module min_slice #(
    parameter int M = 8
) (
    input  logic [M-1:0] col,
    input  logic [M-1:0] h,
    output logic [M-1:0] h_next
);

    logic [M-1:0] h_b;

    always_comb begin
        h_b    = h & ~col;
        h_next = (h_b != '0) ? h_b : h;
    end

endmodule

// File: rtl/min_sort_engine.sv
// Bit-serial selection sort: emits the masked words smallest-first, W+1 cycles per result.
// Optional macro SORT_DESC_EN adds i_desc to select descending order per load.
module min_sort_engine
    import sort_pkg::*;
#(
    parameter int M = SORT_M_DEF,
    parameter int W = SORT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [M*W-1:0]       i_data,
    input  logic [M-1:0]         i_mask,
`ifdef SORT_DESC_EN
    input  logic                 i_desc,
`endif
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [$clog2(M)-1:0] o_idx,
    output logic [W-1:0]         o_value,
    output logic                 o_last
);

    localparam int IW = $clog2(M);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    sort_state_t    state;
    logic [M*W-1:0] data_r;
    logic [M-1:0]   act;
    logic [M-1:0]   h;
    logic [BW-1:0]  bitcnt;
    logic [M-1:0]   col;
    logic [M-1:0]   col_eff;
    logic [M-1:0]   h_nxt;
    logic [M-1:0]   act_rem;
    logic [IW-1:0]  win;
    logic           found;
    logic           act_one;
`ifdef SORT_DESC_EN
    logic           desc_r;
`endif

    always_comb begin
        col = '0;
        for (int unsigned k = 0; k < M; k++) begin
            col[k] = data_r[k*W + int'(bitcnt)];
        end
`ifdef SORT_DESC_EN
        // Feeding the inverted column makes the same slice keep the 1-bits.
        col_eff = desc_r ? ~col : col;
`else
        col_eff = col;
`endif
    end

    min_slice #(.M(M)) u_slice (
        .col    (col_eff),
        .h      (h),
        .h_next (h_nxt)
    );

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < M; k++) begin
            if (h_nxt[k] && !found) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
        act_one        = (act != '0) && ((act & (act - M'(1))) == '0);
        act_rem        = act;
        act_rem[o_idx] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            data_r  <= '0;
            act     <= '0;
            h       <= '0;
            bitcnt  <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_idx   <= '0;
            o_value <= '0;
            o_last  <= 1'b0;
`ifdef SORT_DESC_EN
            desc_r  <= 1'b0;
`endif
        end else if (i_flush) begin
            state   <= IDLE;
            act     <= '0;
            h       <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_idx   <= '0;
            o_value <= '0;
            o_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        data_r <= i_data;
                        act    <= i_mask;
                        h      <= i_mask;
                        bitcnt <= BW'(W - 1);
`ifdef SORT_DESC_EN
                        desc_r <= i_desc;
`endif
                        if (i_mask != '0) begin
                            state   <= SCAN;
                            o_ready <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    h <= h_nxt;
                    if (bitcnt == '0) begin
                        // Result registers are loaded from the final reduction step.
                        state   <= EMIT;
                        o_valid <= 1'b1;
                        o_idx   <= win;
                        o_value <= data_r[int'(win)*W +: W];
                        o_last  <= act_one;
                    end else begin
                        bitcnt <= bitcnt - BW'(1);
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_idx   <= '0;
                        o_value <= '0;
                        o_last  <= 1'b0;
                        act     <= act_rem;
                        if (act_rem != '0) begin
                            h      <= act_rem;
                            bitcnt <= BW'(W - 1);
                            state  <= SCAN;
                        end else begin
                            h       <= '0;
                            state   <= IDLE;
                            o_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_sort_engine.sv
// Directed scoreboard bench for min_sort_engine with M=4, W=4.
module tb_min_sort_engine;

    localparam int M = 4;
    localparam int W = 4;

    logic           i_clk   = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_flush = 1'b0;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b1;
    logic [M*W-1:0] i_data  = '0;
    logic [M-1:0]   i_mask  = '0;
`ifdef SORT_DESC_EN
    logic           i_desc  = 1'b0;
`endif
    logic           o_ready;
    logic           o_valid;
    logic [1:0]     o_idx;
    logic [W-1:0]   o_value;
    logic           o_last;

    min_sort_engine #(.M(M), .W(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_mask  (i_mask),
`ifdef SORT_DESC_EN
        .i_desc  (i_desc),
`endif
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_idx   (o_idx),
        .o_value (o_value),
        .o_last  (o_last)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] value;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compare on every accepted result, and require zeros when idle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_idx", int'(o_idx), int'(mon_e.idx));
                    check("result_value", int'(o_value), int'(mon_e.value));
                    check("result_last", int'(o_last), int'(mon_e.last));
                end
            end else if (!o_valid) begin
                check("idle_outputs_zero", int'({o_idx, o_value, o_last}), 0);
            end
        end
    end

    function automatic logic [15:0] pack(input logic [3:0] w0, input logic [3:0] w1,
                                         input logic [3:0] w2, input logic [3:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input logic [3:0] val, input logic last);
        exp_t e;
        e.idx   = idx;
        e.value = val;
        e.last  = last;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] m, input logic desc);
        i_data  = d;
        i_mask  = m;
`ifdef SORT_DESC_EN
        i_desc  = desc;
`endif
        i_valid = 1'b1;
        hs_cyc  = cyc;
        tick();
        i_valid = 1'b0;
        if (desc) hs_cyc = hs_cyc + 0;
    endtask

    task automatic wait_valid(output int seen_cyc);
        seen_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_valid) begin
                seen_cyc = cyc;
                break;
            end
        end
        if (seen_cyc < 0) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge i_clk);
        end
        check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         seen;
        logic [6:0] cap;

        // Reset state while reset is held
        #12;
        check("reset_ready", int'(o_ready), 1);
        check("reset_valid", int'(o_valid), 0);
        check("reset_outputs", int'({o_idx, o_value, o_last}), 0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Ascending order with latency check
        push(2'd3, 4'd0, 1'b0);
        push(2'd1, 4'd1, 1'b0);
        push(2'd2, 4'd2, 1'b0);
        push(2'd0, 4'd3, 1'b1);
        load(pack(4'd3, 4'd1, 4'd2, 4'd0), 4'b1111, 1'b0);
        check("ready_low_in_scan", int'(o_ready), 0);
        wait_valid(seen);
        check("first_valid_latency", seen - hs_cyc, W + 1);
        drain();
        check("ready_after_asc", int'(o_ready), 1);

        // Ties resolve to lowest index
        for (int k = 0; k < 4; k++) push(2'(k), 4'd5, k == 3);
        load(pack(4'd5, 4'd5, 4'd5, 4'd5), 4'b1111, 1'b0);
        drain();
        check("ready_after_ties", int'(o_ready), 1);

        // Backpressure: outputs hold while i_ready is low
        i_ready = 1'b0;
        push(2'd3, 4'd0, 1'b0);
        push(2'd1, 4'd1, 1'b0);
        push(2'd2, 4'd2, 1'b0);
        push(2'd0, 4'd3, 1'b1);
        load(pack(4'd3, 4'd1, 4'd2, 4'd0), 4'b1111, 1'b0);
        wait_valid(seen);
        cap = {o_idx, o_value, o_last};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", int'(o_valid), 1);
            check("bp_hold_outputs", int'({o_idx, o_value, o_last}), int'(cap));
            check("bp_ready_low", int'(o_ready), 0);
        end
        i_ready = 1'b1;
        drain();
        check("ready_after_bp", int'(o_ready), 1);

        // Partial mask
        push(2'd3, 4'd4, 1'b0);
        push(2'd1, 4'd9, 1'b1);
        load(pack(4'd0, 4'd9, 4'd0, 4'd4), 4'b1010, 1'b0);
        drain();
        check("ready_after_partial", int'(o_ready), 1);

        // Empty mask: no result, stays ready
        load(pack(4'd1, 4'd2, 4'd3, 4'd4), 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("zero_mask_ready", int'(o_ready), 1);
            check("zero_mask_no_valid", int'(o_valid), 0);
            tick();
        end

        // Flush in the second SCAN cycle
        load(pack(4'd3, 4'd1, 4'd2, 4'd0), 4'b1111, 1'b0);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_to_idle", int'(o_ready), 1);
        for (int i = 0; i < W + 3; i++) begin
            check("flush_no_valid", int'(o_valid), 0);
            tick();
        end

        // Reset asserted during EMIT clears outputs at once
        i_ready = 1'b0;
        load(pack(4'd3, 4'd1, 4'd2, 4'd0), 4'b1111, 1'b0);
        wait_valid(seen);
        tick();
        check("emit_before_reset", int'(o_valid), 1);
        i_rst_n = 1'b0;
        #1;
        check("rst_emit_valid", int'(o_valid), 0);
        check("rst_emit_outputs", int'({o_idx, o_value, o_last}), 0);
        check("rst_emit_ready", int'(o_ready), 1);
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        push(2'd0, 4'd7, 1'b1);
        load(pack(4'd7, 4'd0, 4'd0, 4'd0), 4'b0001, 1'b0);
        drain();
        check("ready_after_reset_load", int'(o_ready), 1);

`ifdef SORT_DESC_EN
        push(2'd0, 4'd3, 1'b0);
        push(2'd2, 4'd2, 1'b0);
        push(2'd1, 4'd1, 1'b0);
        push(2'd3, 4'd0, 1'b1);
        load(pack(4'd3, 4'd1, 4'd2, 4'd0), 4'b1111, 1'b1);
        drain();
        i_desc = 1'b0;
        check("ready_after_desc", int'(o_ready), 1);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
